clock_core12: RTL and testbench
===============================

Name: clock_core12

Overview:
12-hour timekeeping core that owns the running time registers. It consumes the hours/mins/secs/AM-PM values produced by the set-time path through a load strobe. It advances time once per second, derived from the system clock by an internal prescaler. Its outputs drive the display/mode logic as the authoritative current time.

Parameters:
TICK_DIV, 100000000, system clock cycles per one-second tick (≥2; benches use 4)
CNT_W, 27, prescaler counter width (must hold TICK_DIV-1)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
run_i  input  1  1 = prescaler counts; 0 = time frozen (prescaler holds value)
load_i  input  1  one-cycle strobe: capture hours_i/mins_i/secs_i/A_P_i
hours_i  input  5  hour to load, legal 1..12
mins_i  input  6  minute to load, legal 0..59
secs_i  input  6  second to load, legal 0..59
A_P_i  input  1  0 = AM, 1 = PM
hours_o  output  5  current hour 1..12
mins_o  output  6  current minute 0..59
secs_o  output  6  current second 0..59
A_P_o  output  1  current AM/PM
sec_pulse_o  output  1  one-cycle pulse in the cycle the time outputs change due to a tick
load_ack_o  output  1  one-cycle pulse: load accepted
load_err_o  output  1  one-cycle pulse: load rejected (out-of-range field)

Behaviour:
- Reset (async assert, sync release): hours_o=12, mins_o=0, secs_o=0, A_P_o=0, prescaler=0, all pulses 0.
- All outputs are registered. No combinational path from inputs to outputs.
- Prescaler: when run_i=1, count 0..TICK_DIV-1. The internal tick is asserted in the cycle count==TICK_DIV-1, and the count wraps to 0. When run_i=0, the count holds and no tick is generated.
- Tick update (takes effect at the clock edge ending the tick cycle; sec_pulse_o high that same following cycle):
  - secs<59: secs+1.
  - secs==59: secs=0, carry into mins.
  - mins==59 with carry: mins=0, carry into hours.
  - hours with carry: 11->12 and toggle A_P; 12->1 with no toggle; otherwise +1.
  - So 11:59:59 AM -> 12:00:00 PM, 11:59:59 PM -> 12:00:00 AM, and 12:59:59 -> 01:00:00 with A_P unchanged.
- Load validation: legal if 1≤hours_i≤12, mins_i≤59 and secs_i≤59. A_P_i is always legal.
- Legal load:
  - The next cycle shows the input values on the outputs, with load_ack_o=1.
  - The prescaler is cleared to 0, so the first tick after a load comes a full TICK_DIV cycles later.
- Illegal load: time registers and prescaler are unchanged. load_err_o=1 for one cycle. A tick in the same cycle is applied normally.
- Simultaneous legal load and tick: the load wins, the tick is discarded, and sec_pulse_o stays 0.
- A load is accepted regardless of run_i.
- Back-to-back load_i strobes are each evaluated independently, one per cycle.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Any pending pulse is dropped.
- Out-of-range internal state cannot arise: there is no path that writes illegal values.

Decomposition:
- Package clock12_pkg:
  - constants HOUR_MIN=1, HOUR_MAX=12, MIN_MAX=59, SEC_MAX=59
  - field widths HOUR_W=5, MIN_W=6, SEC_W=6
  - reset time constants RST_HOUR=12, RST_MIN=0, RST_SEC=0, RST_AP=0
- One sub-module, tick_prescaler (parameters TICK_DIV, CNT_W; ports clk, rst, run_i, clr_i, tick_o).
- Validation, carry chain and AM/PM toggle stay in clock_core12.

Test Plan:
1. Reset, then run_i=1, TICK_DIV=4 -> outputs 12:00:00 AM; secs_o=1 after 4 cycles; sec_pulse_o pulses every 4th cycle.
2. Load 11:59:59 AM then run -> load_ack_o pulse. After 4 cycles: 12:00:00 PM, A_P_o=1. Repeat from 11:59:59 PM -> 12:00:00 AM.
3. Load 12:59:59 PM, tick -> 01:00:00 PM, A_P_o unchanged. Load 05:09:59, tick -> 05:10:00.
4. Illegal loads: hours 0, hours 13, mins 60, secs 63 -> each gives a load_err_o pulse. Time and prescaler phase are unchanged (next tick arrives on original schedule).
5. Legal load 03:30:15 in the same cycle as a tick -> outputs 03:30:15 with no sec_pulse_o. The next tick comes exactly 4 cycles later (secs 16).
6. run_i=0 for 10 cycles mid-count -> time frozen, no pulses; resumes with remaining count. Assert rst mid-count -> immediate 12:00:00 AM.

Source files
------------

// File: rtl/clock12_pkg.sv
// ---------------------------------------------------------------------------
// clock12_pkg
// Shared constants and types for the 12-hour timekeeping core.
//   - Field widths for hours / minutes / seconds
//   - Legal range limits for each field
//   - Time value that the core takes after reset
//   - time_t bundles the full time so it moves around as one value
//   - time_is_legal() range-checks a candidate time before it is loaded
// ---------------------------------------------------------------------------
package clock12_pkg;

   localparam int HOUR_W = 5;
   localparam int MIN_W  = 6;
   localparam int SEC_W  = 6;

   localparam logic [HOUR_W-1:0] HOUR_MIN = 5'd1;
   localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd12;
   localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
   localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;

   localparam logic [HOUR_W-1:0] RST_HOUR = 5'd12;
   localparam logic [MIN_W-1:0]  RST_MIN  = 6'd0;
   localparam logic [SEC_W-1:0]  RST_SEC  = 6'd0;
   localparam logic              RST_AP   = 1'b0;

   typedef struct packed {
      logic [HOUR_W-1:0] hours;
      logic [MIN_W-1:0]  mins;
      logic [SEC_W-1:0]  secs;
      logic              a_p;
   } time_t;

   // A time is legal when every field is inside its range. AM/PM is a
   // single bit, so both of its values are meaningful and it is never checked.
   function automatic logic time_is_legal(input time_t t);
      return (t.hours >= HOUR_MIN) && (t.hours <= HOUR_MAX) &&
             (t.mins <= MIN_MAX) && (t.secs <= SEC_MAX);
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Divides the system clock down to a once-per-TICK_DIV-cycles tick.
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-high reset, clears the count
//   run_i  - 1 = count, 0 = hold the count and suppress the tick
//   clr_i  - synchronous clear back to 0 (used when a new time is loaded)
//   tick_o - high for the single cycle in which count == TICK_DIV-1
// ---------------------------------------------------------------------------
module tick_prescaler #(
   parameter int TICK_DIV = 100000000,
   parameter int CNT_W    = 27
) (
   input  logic clk,
   input  logic rst,
   input  logic run_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] count;

   // The tick comes straight from the count register, so it is clean and lines
   // up with the cycle in which the count sits at its last value. When stopped,
   // the count sits still and the tick is masked.
   assign tick_o = run_i && (count == CNT_LAST);

   // A clear takes priority over counting, so the first tick after a load comes
   // a full TICK_DIV cycles later. Otherwise the count wraps from its last value
   // back to 0 as the tick fires.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr_i) begin
         count <= '0;
      end else if (run_i) begin
         if (count == CNT_LAST) begin
            count <= '0;
         end else begin
            count <= count + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/clock_core12.sv
// ---------------------------------------------------------------------------
// clock_core12
// 12-hour timekeeping core. It holds the authoritative running time, advances
// it once per second, and accepts new times from the set-time path.
// Ports:
//   clk, rst            - system clock / asynchronous active-high reset
//   run_i               - 1 = time advances, 0 = time frozen
//   load_i              - one-cycle strobe that loads hours_i/mins_i/secs_i/A_P_i
//   hours_i .. A_P_i    - time to load (hours 1..12, mins/secs 0..59)
//   hours_o .. A_P_o    - current time (registered)
//   sec_pulse_o         - one-cycle pulse when the time changes because of a tick
//   load_ack_o          - one-cycle pulse: the load was accepted
//   load_err_o          - one-cycle pulse: the load was rejected as out of range
// ---------------------------------------------------------------------------
module clock_core12
   import clock12_pkg::*;
#(
   parameter int TICK_DIV = 100000000,
   parameter int CNT_W    = 27
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run_i,
   input  logic              load_i,
   input  logic [HOUR_W-1:0] hours_i,
   input  logic [MIN_W-1:0]  mins_i,
   input  logic [SEC_W-1:0]  secs_i,
   input  logic              A_P_i,
   output logic [HOUR_W-1:0] hours_o,
   output logic [MIN_W-1:0]  mins_o,
   output logic [SEC_W-1:0]  secs_o,
   output logic              A_P_o,
   output logic              sec_pulse_o,
   output logic              load_ack_o,
   output logic              load_err_o
);

   localparam time_t RST_TIME = '{hours: RST_HOUR, mins: RST_MIN,
                                  secs: RST_SEC, a_p: RST_AP};

   time_t cur_time;
   time_t adv_time;
   time_t load_time;
   logic  tick;
   logic  load_ok;
   logic  sec_pulse_q;
   logic  load_ack_q;
   logic  load_err_q;

   assign load_time = '{hours: hours_i, mins: mins_i, secs: secs_i, a_p: A_P_i};

   // A legal load also restarts the prescaler. A rejected load leaves the
   // prescaler alone so the one-second schedule is not disturbed.
   assign load_ok = load_i && time_is_legal(load_time);

   tick_prescaler #(
      .TICK_DIV (TICK_DIV),
      .CNT_W    (CNT_W)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .run_i  (run_i),
      .clr_i  (load_ok),
      .tick_o (tick)
   );

   // Carry chain: the value the time would take after one tick. Seconds roll
   // into minutes, and minutes into hours. Hours run 12,1,2..11,12. AM/PM flips
   // only on 11 -> 12, never on the 12 -> 1 wrap.
   always_comb begin
      adv_time = cur_time;
      if (cur_time.secs == SEC_MAX) begin
         adv_time.secs = '0;
         if (cur_time.mins == MIN_MAX) begin
            adv_time.mins = '0;
            if (cur_time.hours == HOUR_MAX) begin
               adv_time.hours = HOUR_MIN;
            end else begin
               adv_time.hours = cur_time.hours + HOUR_W'(1);
               if (cur_time.hours == (HOUR_MAX - HOUR_W'(1))) begin
                  adv_time.a_p = ~cur_time.a_p;
               end
            end
         end else begin
            adv_time.mins = cur_time.mins + MIN_W'(1);
         end
      end else begin
         adv_time.secs = cur_time.secs + SEC_W'(1);
      end
   end

   // Time register and status pulses. A legal load wins over a tick arriving in
   // the same cycle: that tick is thrown away and no second pulse is reported.
   // A rejected load does not block a tick in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_time    <= RST_TIME;
         sec_pulse_q <= 1'b0;
         load_ack_q  <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         sec_pulse_q <= 1'b0;
         load_ack_q  <= load_ok;
         load_err_q  <= load_i && !load_ok;
         if (load_ok) begin
            cur_time <= load_time;
         end else if (tick) begin
            cur_time    <= adv_time;
            sec_pulse_q <= 1'b1;
         end
      end
   end

   assign hours_o     = cur_time.hours;
   assign mins_o      = cur_time.mins;
   assign secs_o      = cur_time.secs;
   assign A_P_o       = cur_time.a_p;
   assign sec_pulse_o = sec_pulse_q;
   assign load_ack_o  = load_ack_q;
   assign load_err_o  = load_err_q;

endmodule

// File: tb/tb_clock_core12.sv
// ---------------------------------------------------------------------------
// tb_clock_core12
// Directed self-checking bench for clock_core12 with TICK_DIV = 4.
// Inputs change 1 ns after a rising edge. Outputs are checked there too, so
// each check sees the result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_clock_core12;

   logic       clk;
   logic       rst;
   logic       run_i;
   logic       load_i;
   logic [4:0] hours_i;
   logic [5:0] mins_i;
   logic [5:0] secs_i;
   logic       A_P_i;
   logic [4:0] hours_o;
   logic [5:0] mins_o;
   logic [5:0] secs_o;
   logic       A_P_o;
   logic       sec_pulse_o;
   logic       load_ack_o;
   logic       load_err_o;

   int checks;
   int failures;

   clock_core12 #(
      .TICK_DIV (4),
      .CNT_W    (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .run_i       (run_i),
      .load_i      (load_i),
      .hours_i     (hours_i),
      .mins_i      (mins_i),
      .secs_i      (secs_i),
      .A_P_i       (A_P_i),
      .hours_o     (hours_o),
      .mins_o      (mins_o),
      .secs_o      (secs_o),
      .A_P_o       (A_P_o),
      .sec_pulse_o (sec_pulse_o),
      .load_ack_o  (load_ack_o),
      .load_err_o  (load_err_o)
   );

   // 10 ns system clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: bump the count, fail loudly on any difference
   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Compare the whole time bundle plus the tick pulse
   task automatic checkTime(input string tag, input int h, input int m,
                            input int s, input int ap, input int pulse);
      checkOutput({tag, ".hours"}, 32'(hours_o), 32'(h));
      checkOutput({tag, ".mins"},  32'(mins_o),  32'(m));
      checkOutput({tag, ".secs"},  32'(secs_o),  32'(s));
      checkOutput({tag, ".ap"},    32'(A_P_o),   32'(ap));
      checkOutput({tag, ".pulse"}, 32'(sec_pulse_o), 32'(pulse));
   endtask

   task automatic stepCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic ld, input int h, input int m,
                                input int s, input logic ap);
      load_i  = ld;
      hours_i = 5'(h);
      mins_i  = 6'(m);
      secs_i  = 6'(s);
      A_P_i   = ap;
   endtask

   // Legal load on one edge, strobe dropped right after
   task automatic loadTime(input int h, input int m, input int s, input logic ap);
      applyStimulus(1'b1, h, m, s, ap);
      stepCycles(1);
      load_i = 1'b0;
   endtask

   int badH [4] = '{0, 13, 5, 5};
   int badM [4] = '{10, 10, 60, 10};
   int badS [4] = '{0, 0, 0, 63};

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      run_i    = 1'b0;
      applyStimulus(1'b0, 0, 0, 0, 1'b0);

      // Reset state
      #12;
      checkTime("reset", 12, 0, 0, 0, 0);
      checkOutput("reset.ack", 32'(load_ack_o), 32'd0);
      checkOutput("reset.err", 32'(load_err_o), 32'd0);
      @(posedge clk);
      #1;
      rst   = 1'b0;
      run_i = 1'b1;

      // Free running: one tick every fourth edge
      $display("[TB] free-running ticks");
      for (int i = 1; i <= 8; i++) begin
         stepCycles(1);
         checkOutput("run.pulse", 32'(sec_pulse_o), (i % 4 == 0) ? 32'd1 : 32'd0);
         if (i == 4) checkOutput("run.secs1", 32'(secs_o), 32'd1);
      end
      checkTime("run.after8", 12, 0, 2, 0, 1);

      // 11:59:59 AM -> 12:00:00 PM, then 11:59:59 PM -> 12:00:00 AM
      $display("[TB] AM/PM rollover");
      loadTime(11, 59, 59, 1'b0);
      checkTime("ld1159am", 11, 59, 59, 0, 0);
      checkOutput("ld1159am.ack", 32'(load_ack_o), 32'd1);
      stepCycles(3);
      checkTime("ld1159am.wait", 11, 59, 59, 0, 0);
      checkOutput("ld1159am.ackgone", 32'(load_ack_o), 32'd0);
      stepCycles(1);
      checkTime("roll.am2pm", 12, 0, 0, 1, 1);
      loadTime(11, 59, 59, 1'b1);
      checkOutput("ld1159pm.ack", 32'(load_ack_o), 32'd1);
      stepCycles(4);
      checkTime("roll.pm2am", 12, 0, 0, 0, 1);

      // 12:59:59 PM -> 01:00:00 PM, and a plain minute carry
      $display("[TB] hour wrap and minute carry");
      loadTime(12, 59, 59, 1'b1);
      stepCycles(4);
      checkTime("wrap.12to1", 1, 0, 0, 1, 1);
      loadTime(5, 9, 59, 1'b0);
      stepCycles(4);
      checkTime("carry.min", 5, 10, 0, 0, 1);

      // Illegal loads: rejected, schedule undisturbed; the fourth lands on a tick
      $display("[TB] illegal loads");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, badH[i], badM[i], badS[i], 1'b1);
         stepCycles(1);
         checkOutput("bad.err", 32'(load_err_o), 32'd1);
         checkOutput("bad.ack", 32'(load_ack_o), 32'd0);
         if (i < 3) checkTime("bad.hold", 5, 10, 0, 0, 0);
         else       checkTime("bad.tick", 5, 10, 1, 0, 1);
      end
      load_i = 1'b0;

      // Legal load in the same cycle as a tick: load wins, no pulse
      $display("[TB] load colliding with tick");
      stepCycles(3);
      checkOutput("coll.errgone", 32'(load_err_o), 32'd0);
      checkTime("coll.pre", 5, 10, 1, 0, 0);
      loadTime(3, 30, 15, 1'b0);
      checkTime("coll.load", 3, 30, 15, 0, 0);
      checkOutput("coll.ack", 32'(load_ack_o), 32'd1);
      stepCycles(3);
      checkTime("coll.wait", 3, 30, 15, 0, 0);
      stepCycles(1);
      checkTime("coll.tick", 3, 30, 16, 0, 1);

      // Freeze mid-count for 10 cycles, then resume with the remaining count
      $display("[TB] run_i freeze");
      stepCycles(2);
      run_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         stepCycles(1);
         checkTime("freeze", 3, 30, 16, 0, 0);
      end
      run_i = 1'b1;
      stepCycles(1);
      checkTime("resume.wait", 3, 30, 16, 0, 0);
      stepCycles(1);
      checkTime("resume.tick", 3, 30, 17, 0, 1);

      // Asynchronous reset while a pulse is showing
      $display("[TB] mid-run reset");
      stepCycles(4);
      checkTime("prerst", 3, 30, 18, 0, 1);
      rst = 1'b1;
      #1;
      checkTime("asyncrst", 12, 0, 0, 0, 0);
      stepCycles(2);
      checkTime("rsthold", 12, 0, 0, 0, 0);
      rst = 1'b0;
      stepCycles(3);
      checkTime("postrst.wait", 12, 0, 0, 0, 0);
      stepCycles(1);
      checkTime("postrst.tick", 12, 0, 1, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
